// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 read path: FSM states, default bus timing, bit/RS encodings.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_EHIGH,
    ST_ELOW,
    ST_EVAL,
    ST_DONE
  } rd_state_e;

  localparam int DEF_T_AS     = 3;
  localparam int DEF_T_EH     = 13;
  localparam int DEF_T_EL     = 13;
  localparam int DEF_POLL_MAX = 65535;

  localparam int BF_BIT = 7;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Phase timer width: enough for the longest phase, never below 5 bits.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 5) ? 5 : w;
  endfunction

endpackage

// File: rtl/lcd1602_reader_if.sv
// Host, arbiter and LCD pin signals of the reader; slave = reader side, master = environment side.
interface lcd1602_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic       poll_bf;
  logic       rd_busy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_timeout;
  logic       bus_req;
  logic       bus_gnt;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_db_i;

  modport slave (
    input  rd_req, rd_rs, poll_bf, bus_gnt, lcd_db_i,
    output rd_busy, rd_valid, rd_data, rd_timeout, bus_req, lcd_rs, lcd_rw, lcd_en
  );

  modport master (
    output rd_req, rd_rs, poll_bf, bus_gnt, lcd_db_i,
    input  rd_busy, rd_valid, rd_data, rd_timeout, bus_req, lcd_rs, lcd_rw, lcd_en
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done_o is high on the last cycle of the loaded phase.
// Load N-1 to get an N-cycle phase; loading while done starts the next phase back to back.
module lcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd1602_reader.sv
// LCD1602 read engine: arbitrates for the pins, runs RW=1 E cycles, optionally polls BF.
// Single read completes 3+T_AS+T_EH+T_EL cycles after the request; waits in ARB while no grant.
module lcd1602_reader
  import lcd1602_pkg::*;
#(
  parameter int T_AS     = DEF_T_AS,
  parameter int T_EH     = DEF_T_EH,
  parameter int T_EL     = DEF_T_EL,
  parameter int POLL_MAX = DEF_POLL_MAX
) (
  input logic              clk,
  input logic              rst,
  lcd1602_reader_if.slave  bus
);

  localparam int              TW       = timer_width(T_AS, T_EH, T_EL);
  localparam logic [TW-1:0]   LD_AS    = TW'(T_AS - 1);
  localparam logic [TW-1:0]   LD_EH    = TW'(T_EH - 1);
  localparam logic [TW-1:0]   LD_EL    = TW'(T_EL - 1);
  localparam logic [15:0]     POLL_CAP = 16'(POLL_MAX);

  rd_state_e   state_q;
  logic        rs_q;
  logic        poll_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [7:0]  data_q;
  logic        timeout_q;
  logic        busy_q;
  logic        valid_q;
  logic        req_q;
  logic        lcd_rs_q;
  logic        lcd_rw_q;
  logic        lcd_en_q;

  logic          timed;
  logic          tmr_load;
  logic          tmr_done;
  logic [TW-1:0] tmr_val;

  // Outside the timed phases the timer is kept primed with the SETUP length.
  assign timed    = state_q inside {ST_SETUP, ST_EHIGH, ST_ELOW};
  assign tmr_load = !timed || tmr_done;

  always_comb begin
    tmr_val = LD_AS;
    case (state_q)
      ST_SETUP: tmr_val = LD_EH;
      ST_EHIGH: tmr_val = LD_EL;
      default:  tmr_val = LD_AS;
    endcase
  end

  lcd_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rs_q      <= RS_CMD;
      poll_q    <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      lcd_rs_q  <= RS_CMD;
      lcd_rw_q  <= 1'b0;
      lcd_en_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.rd_req) begin
            rs_q      <= bus.rd_rs;
            poll_q    <= bus.poll_bf && (bus.rd_rs != RS_DATA);
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            req_q     <= 1'b1;
            state_q   <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (bus.bus_gnt) begin
            lcd_rw_q <= 1'b1;
            lcd_rs_q <= rs_q;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            lcd_en_q <= 1'b1;
            state_q  <= ST_EHIGH;
          end
        end
        ST_EHIGH: begin
          if (tmr_done) begin
            lcd_en_q <= 1'b0;
            data_q   <= bus.lcd_db_i;
            state_q  <= ST_ELOW;
          end
        end
        ST_ELOW: begin
          if (tmr_done) state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          cnt_q <= cnt_d;
          if (poll_q && data_q[BF_BIT] && (cnt_d < POLL_CAP)) begin
            state_q <= ST_SETUP;
          end else begin
            timeout_q <= poll_q && data_q[BF_BIT];
            valid_q   <= 1'b1;
            req_q     <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_rs_q  <= RS_CMD;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_busy    = busy_q;
  assign bus.rd_valid   = valid_q;
  assign bus.rd_data    = data_q;
  assign bus.rd_timeout = timeout_q;
  assign bus.bus_req    = req_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = lcd_rw_q;
  assign bus.lcd_en     = lcd_en_q;

endmodule
